dmp_stream_collector: RTL and testbench

- Receiving end of the deterministic serial pagerank stream: consumes one thread packet per cycle, in thread order 0..NUM_HW_THREADS-1.
- Each packet carries NODES_IN_GRAPH pagerank values. The block reduces them into per-node sums and raises result_valid once every thread's packet has arrived.
- Sits between the stream serializer and the apply/update stage. Because arrival order is fixed, the reduction is deterministic.

---
 rtl/dmp_pkg.sv | 14 +
 rtl/dmp_stream_collector_if.sv | 28 ++
 rtl/dmp_beat_counter.sv | 23 ++
 rtl/dmp_stream_collector.sv | 99 +++++++++
 tb/tb_dmp_stream_collector.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmp_pkg.sv
// Shared types for the pagerank stream collector: FSM states and word type.
package dmp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } collector_state_t;

   localparam int PR_WIDTH_DEFAULT = 64;

   typedef logic [63:0] pr_word_t;

endpackage

// File: rtl/dmp_stream_collector_if.sv
// Serializer-to-collector stream bundle: start/valid/done strobes plus one packet.
interface dmp_stream_collector_if
   import dmp_pkg::*;
#(
   parameter int NODES_IN_GRAPH = 32,
   parameter int PR_WIDTH       = PR_WIDTH_DEFAULT
);

   logic                stream_start;
   logic                stream_valid;
   logic                stream_done;
   logic [PR_WIDTH-1:0] pagerank_serial_stream [NODES_IN_GRAPH];

   modport master (
      output stream_start,
      output stream_valid,
      output stream_done,
      output pagerank_serial_stream
   );

   modport slave (
      input stream_start,
      input stream_valid,
      input stream_done,
      input pagerank_serial_stream
   );

endinterface

// File: rtl/dmp_beat_counter.sv
// Counts accepted beats; saturates at MAX_COUNT, cleared by reset or clear.
module dmp_beat_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MAX_COUNT);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != COUNT_MAX)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/dmp_stream_collector.sv
// Reduces NUM_HW_THREADS in-order packets into per-node pagerank sums and
// flags completion or protocol violations until the next iteration.
module dmp_stream_collector
   import dmp_pkg::*;
#(
   parameter int NUM_HW_THREADS = 8,
   parameter int NODES_IN_GRAPH = 32,
   parameter int PR_WIDTH       = PR_WIDTH_DEFAULT,
   localparam int CNT_W         = $clog2(NUM_HW_THREADS + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   nextIteration,
   dmp_stream_collector_if.slave  stream,
   output logic [PR_WIDTH-1:0]    pagerank_sum [NODES_IN_GRAPH],
   output logic                   result_valid,
   output logic [CNT_W-1:0]       beat_count,
   output logic                   protocol_error,
   output logic                   busy
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_HW_THREADS - 1);

   collector_state_t state, state_next;
   logic             result_next;
   logic             error_next;
   logic             accept;
   logic             last_beat;

   // Unsigned modulo-2^PR_WIDTH add: overflow wraps by design.
   function automatic logic [PR_WIDTH-1:0] add_wrap(input logic [PR_WIDTH-1:0] a,
                                                    input logic [PR_WIDTH-1:0] b);
      return a + b;
   endfunction

   assign accept    = (state == COLLECT) && stream.stream_valid && !nextIteration;
   assign last_beat = accept && (beat_count == LAST_BEAT);
   assign busy      = (state == COLLECT);

   dmp_beat_counter #(
      .WIDTH     (CNT_W),
      .MAX_COUNT (NUM_HW_THREADS)
   ) u_beat_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (nextIteration),
      .enable (accept),
      .count  (beat_count)
   );

   always_ff @(posedge clock) begin
      if (reset || nextIteration) begin
         state          <= IDLE;
         result_valid   <= 1'b0;
         protocol_error <= 1'b0;
      end else begin
         state          <= state_next;
         result_valid   <= result_next;
         protocol_error <= error_next;
      end
   end

   // A beat arriving with stream_done is counted first; only a short count is an error.
   always_comb begin
      state_next  = state;
      result_next = result_valid;
      error_next  = protocol_error;
      case (state)
         IDLE: begin
            if (stream.stream_valid) error_next = 1'b1;
            if (stream.stream_start) state_next = COLLECT;
         end
         COLLECT: begin
            if (last_beat) begin
               state_next  = HOLD;
               result_next = 1'b1;
            end else if (stream.stream_done) begin
               state_next = HOLD;
               error_next = 1'b1;
            end
         end
         HOLD: begin
            if (stream.stream_valid) error_next = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NODES_IN_GRAPH; i++) begin
         if (reset || nextIteration) begin
            pagerank_sum[i] <= '0;
         end else if (accept) begin
            pagerank_sum[i] <= add_wrap(pagerank_sum[i], stream.pagerank_serial_stream[i]);
         end
      end
   end

endmodule

// File: tb/tb_dmp_stream_collector.sv
// Directed bench for dmp_stream_collector with 4 threads x 4 nodes.
module tb_dmp_stream_collector;

   localparam int NT = 4;
   localparam int NN = 4;
   localparam int PW = 64;
   localparam int CW = $clog2(NT + 1);

   logic          clock = 1'b0;
   logic          reset;
   logic          nextIteration;
   logic [PW-1:0] pagerank_sum [NN];
   logic          result_valid;
   logic [CW-1:0] beat_count;
   logic          protocol_error;
   logic          busy;

   int errors = 0;
   int checks = 0;

   dmp_stream_collector_if #(.NODES_IN_GRAPH(NN), .PR_WIDTH(PW)) sif ();

   dmp_stream_collector #(
      .NUM_HW_THREADS (NT),
      .NODES_IN_GRAPH (NN),
      .PR_WIDTH       (PW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .nextIteration  (nextIteration),
      .stream         (sif.slave),
      .pagerank_sum   (pagerank_sum),
      .result_valid   (result_valid),
      .beat_count     (beat_count),
      .protocol_error (protocol_error),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_beat(input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3);
      sif.pagerank_serial_stream[0] = d0;
      sif.pagerank_serial_stream[1] = d1;
      sif.pagerank_serial_stream[2] = d2;
      sif.pagerank_serial_stream[3] = d3;
   endtask

   // Beat t of the reference stream: node i carries t*10+i+1.
   task automatic send_beat(input int t);
      set_beat(64'(t*10+1), 64'(t*10+2), 64'(t*10+3), 64'(t*10+4));
      sif.stream_valid = 1'b1;
      tick();
      sif.stream_valid = 1'b0;
   endtask

   task automatic start_stream();
      sif.stream_start = 1'b1;
      tick();
      sif.stream_start = 1'b0;
   endtask

   task automatic new_iteration();
      nextIteration = 1'b1;
      tick();
      nextIteration = 1'b0;
   endtask

   task automatic check_sums(input string tag, input logic [63:0] e0, input logic [63:0] e1,
                             input logic [63:0] e2, input logic [63:0] e3);
      check_eq({tag, "_sum0"}, pagerank_sum[0], e0);
      check_eq({tag, "_sum1"}, pagerank_sum[1], e1);
      check_eq({tag, "_sum2"}, pagerank_sum[2], e2);
      check_eq({tag, "_sum3"}, pagerank_sum[3], e3);
   endtask

   task automatic check_cleared(input string tag);
      check_sums(tag, 64'd0, 64'd0, 64'd0, 64'd0);
      check_eq({tag, "_cnt"}, 64'(beat_count), 64'd0);
      check_eq({tag, "_rv"}, 64'(result_valid), 64'd0);
      check_eq({tag, "_err"}, 64'(protocol_error), 64'd0);
      check_eq({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic full_stream_check(input string tag, input int gap);
      start_stream();
      check_eq({tag, "_busy"}, 64'(busy), 64'd1);
      for (int t = 0; t < NT; t++) begin
         send_beat(t);
         check_eq({tag, "_rv_timing"}, 64'(result_valid), (t == NT-1) ? 64'd1 : 64'd0);
         if (t < NT-1) begin
            for (int g = 0; g < gap; g++) tick();
         end
      end
      check_sums(tag, 64'd64, 64'd68, 64'd72, 64'd76);
      check_eq({tag, "_cnt"}, 64'(beat_count), 64'd4);
      check_eq({tag, "_err"}, 64'(protocol_error), 64'd0);
      check_eq({tag, "_busy_hold"}, 64'(busy), 64'd0);
      tick();
      tick();
      check_eq({tag, "_rv_stable"}, 64'(result_valid), 64'd1);
      check_sums({tag, "_stable"}, 64'd64, 64'd68, 64'd72, 64'd76);
   endtask

   initial begin
      reset             = 1'b1;
      nextIteration     = 1'b0;
      sif.stream_start  = 1'b0;
      sif.stream_valid  = 1'b0;
      sif.stream_done   = 1'b0;
      set_beat(64'd0, 64'd0, 64'd0, 64'd0);

      // 1: reset
      tick();
      tick();
      reset = 1'b0;
      tick();
      check_cleared("reset");

      // valid beat while idle is ignored but flagged
      send_beat(0);
      check_eq("idle_beat_err", 64'(protocol_error), 64'd1);
      check_eq("idle_beat_cnt", 64'(beat_count), 64'd0);
      check_sums("idle_beat", 64'd0, 64'd0, 64'd0, 64'd0);
      new_iteration();
      check_cleared("idle_next");

      // 2: back-to-back stream
      full_stream_check("b2b", 0);
      new_iteration();
      check_cleared("b2b_next");

      // 3: stream with gaps
      full_stream_check("gap1", 1);
      new_iteration();
      full_stream_check("gap2", 2);

      // beat in HOLD is ignored but flagged
      send_beat(1);
      check_eq("hold_beat_err", 64'(protocol_error), 64'd1);
      check_sums("hold_beat", 64'd64, 64'd68, 64'd72, 64'd76);
      check_eq("hold_beat_cnt", 64'(beat_count), 64'd4);
      new_iteration();
      check_cleared("gap_next");

      // 4: early stream_done
      start_stream();
      send_beat(0);
      send_beat(1);
      sif.stream_done = 1'b1;
      tick();
      sif.stream_done = 1'b0;
      check_eq("early_err", 64'(protocol_error), 64'd1);
      check_eq("early_rv", 64'(result_valid), 64'd0);
      check_eq("early_cnt", 64'(beat_count), 64'd2);
      check_eq("early_busy", 64'(busy), 64'd0);
      check_sums("early", 64'd12, 64'd14, 64'd16, 64'd18);
      new_iteration();
      check_cleared("early_next");

      // stream_done together with final beat completes cleanly
      start_stream();
      send_beat(0);
      send_beat(1);
      send_beat(2);
      sif.stream_done = 1'b1;
      send_beat(3);
      sif.stream_done = 1'b0;
      check_eq("done_last_rv", 64'(result_valid), 64'd1);
      check_eq("done_last_err", 64'(protocol_error), 64'd0);
      check_eq("done_last_cnt", 64'(beat_count), 64'd4);
      new_iteration();

      // 5: wrap-around
      start_stream();
      sif.stream_valid = 1'b1;
      set_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      tick();
      set_beat(64'd1, 64'd1, 64'd1, 64'd1);
      tick();
      tick();
      sif.stream_valid = 1'b0;
      check_sums("wrap", 64'd0, 64'd0, 64'd0, 64'd0);
      check_eq("wrap_rv", 64'(result_valid), 64'd1);
      check_eq("wrap_err", 64'(protocol_error), 64'd0);
      new_iteration();

      // 6a: nextIteration with a concurrent beat
      start_stream();
      send_beat(0);
      send_beat(1);
      nextIteration = 1'b1;
      send_beat(2);
      nextIteration = 1'b0;
      check_cleared("int_next");

      // 6b: reset with a concurrent beat
      start_stream();
      send_beat(0);
      send_beat(1);
      reset = 1'b1;
      send_beat(2);
      reset = 1'b0;
      check_cleared("int_reset");

      // 6c: clean stream after interruption
      full_stream_check("after_int", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
